// File: rtl/melody_pkg.sv
// Shared definitions for the melody player: note codes, pitch table,
// tone divisor helper, built-in score and sequencer state encoding.
package melody_pkg;

    localparam logic [3:0] NOTE_REST = 4'h0;
    localparam logic [3:0] NOTE_END  = 4'hF;

    localparam int unsigned SCORE_LEN = 32;

    // C4 D4 E4 F4 G4 A4 B4 in Hz; index 0 is C4
    localparam logic [6:0][9:0] NOTE_HZ = {10'd494, 10'd440, 10'd392, 10'd349,
                                           10'd330, 10'd293, 10'd261};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PLAY,
        ST_DONE
    } state_t;

    // Pitch of a note code; codes 8-14 sound an octave above 1-7, others are silent
    function automatic int unsigned note_hz(input logic [3:0] code);
        int unsigned hz;
        logic [2:0]  idx;
        hz  = 0;
        idx = 3'(code - 4'd1);
        if (code >= 4'd1 && code <= 4'd7) begin
            hz = 32'(NOTE_HZ[idx]);
        end else if (code >= 4'd8 && code <= 4'd14) begin
            idx = 3'(code - 4'd8);
            hz  = 2 * 32'(NOTE_HZ[idx]);
        end
        return hz;
    endfunction

    // Rounded half-period in clock cycles; never returns 0 so the counter always wraps
    function automatic int unsigned half_div(input int unsigned clk_hz, input int unsigned hz);
        int unsigned d;
        d = 1;
        if (hz != 0) begin
            d = (clk_hz + hz) / (2 * hz);
        end
        if (d == 0) begin
            d = 1;
        end
        return d;
    endfunction

    // {code, dur}: C4..B4, C5 one beat each, one-beat rest (dur 0 counts as 1), end
    localparam logic [7:0] DEFAULT_SCORE [SCORE_LEN] = '{
        8'h11, 8'h21, 8'h31, 8'h41, 8'h51, 8'h61, 8'h71, 8'h81,
        8'h00, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0,
        8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0,
        8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0
    };

    // Score lookup; addresses past the built-in score read as the end marker
    function automatic logic [7:0] score_rom(input int unsigned a);
        logic [4:0] ai;
        logic [7:0] e;
        ai = a[4:0];
        e  = {NOTE_END, 4'h0};
        if (a < SCORE_LEN) begin
            e = DEFAULT_SCORE[ai];
        end
        return e;
    endfunction

endpackage

// File: rtl/melody_player_tone_gen.sv
// Square-wave tone generator: half-period counter plus phase flag,
// producing +/- volume*0x1000 as a 16-bit two's complement sample.
module tone_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] div,
    input  logic        restart,
    input  logic [2:0]  volume,
    input  logic        enable,
    output logic [15:0] sample
);

    logic [31:0] cnt;
    logic        phase;
    logic [15:0] amp;

    // Count half periods; flip the phase each time the divisor is reached
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (restart) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (enable) begin
            if (cnt >= div - 32'd1) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + 32'd1;
            end
        end
    end

    // Map phase to a signed amplitude; silent when not enabled
    always_comb begin
        amp    = {1'b0, volume, 12'h000};
        sample = '0;
        if (enable) begin
            sample = phase ? (16'h0000 - amp) : amp;
        end
    end

endmodule

// File: rtl/melody_player.sv
// Score sequencer: fetches {code, dur} entries, holds each note for
// dur beats and feeds a registered audio word to the I2S serializer.
module melody_player #(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned BEAT_CYCLES = 25_000_000,
    parameter int unsigned SCORE_DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        play,
    input  logic        loop,
    input  logic        mute,
    input  logic [2:0]  volume,
    output logic [15:0] left_audio,
    output logic [15:0] right_audio,
    output logic [3:0]  note_idx,
    output logic        busy,
    output logic        done
);
    import melody_pkg::*;

    localparam int unsigned AW = (SCORE_DEPTH > 1) ? $clog2(SCORE_DEPTH) : 1;

    state_t          state, state_n;
    logic [AW-1:0]   addr, addr_n;
    logic [3:0]      code, code_n;
    logic [31:0]     dur_cnt, dur_n;
    logic [15:0]     audio, audio_n;
    logic            done_n;
    logic            restart;
    logic            tone_en;
    logic [7:0]      entry;
    logic [3:0]      dur_eff;
    logic [31:0]     div;
    logic [15:0]     sample;
    logic [31:0]     div_tab [16];

    for (genvar g = 0; g < 16; g++) begin : g_div
        localparam int unsigned HALF = half_div(CLK_HZ, note_hz(4'(g)));
        assign div_tab[g] = HALF;
    end

    assign entry   = score_rom(32'(addr));
    assign div     = div_tab[code];
    assign tone_en = (state == ST_PLAY);

    tone_gen u_tone (
        .clk     (clk),
        .rst     (rst),
        .div     (div),
        .restart (restart),
        .volume  (volume),
        .enable  (tone_en),
        .sample  (sample)
    );

    // Sequencer and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            addr    <= '0;
            code    <= NOTE_REST;
            dur_cnt <= '0;
            audio   <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            addr    <= addr_n;
            code    <= code_n;
            dur_cnt <= dur_n;
            audio   <= audio_n;
            done    <= done_n;
        end
    end

    // Next-state, score stepping and next audio sample
    always_comb begin
        state_n = state;
        addr_n  = addr;
        code_n  = code;
        dur_n   = dur_cnt;
        restart = 1'b0;
        done_n  = 1'b0;
        dur_eff = (entry[3:0] == 4'd0) ? 4'd1 : entry[3:0];
        case (state)
            ST_IDLE: begin
                if (play) begin
                    state_n = ST_FETCH;
                    addr_n  = '0;
                end
            end
            ST_FETCH: begin
                if (!play) begin
                    state_n = ST_IDLE;
                    addr_n  = '0;
                end else if (entry[7:4] == NOTE_END) begin
                    if (loop) begin
                        addr_n = '0;
                    end else begin
                        state_n = ST_DONE;
                        done_n  = 1'b1;
                    end
                end else begin
                    state_n = ST_PLAY;
                    code_n  = entry[7:4];
                    dur_n   = 32'(dur_eff) * BEAT_CYCLES - 32'd1;
                    restart = 1'b1;
                end
            end
            ST_PLAY: begin
                if (!play) begin
                    state_n = ST_IDLE;
                    addr_n  = '0;
                end else if (dur_cnt == '0) begin
                    state_n = ST_FETCH;
                    addr_n  = addr + AW'(1);
                end else begin
                    dur_n = dur_cnt - 32'd1;
                end
            end
            ST_DONE: begin
                if (!play) begin
                    state_n = ST_IDLE;
                    addr_n  = '0;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        // Stopping silences the output in the same cycle the FSM leaves PLAY
        audio_n = '0;
        if (state == ST_PLAY && play && !mute && code != NOTE_REST) begin
            audio_n = sample;
        end
    end

    // Status outputs decoded from the registered state
    always_comb begin
        left_audio  = audio;
        right_audio = audio;
        note_idx    = (state == ST_PLAY) ? code : 4'd0;
        busy        = (state == ST_FETCH) || (state == ST_PLAY);
    end

endmodule

// File: tb/tb_melody_player.sv
// Directed bench for melody_player with a small clock so C4 divides by 10
// and a beat is 64 cycles; each score entry spans 65 cycles.
module tb_melody_player;

    localparam int unsigned CLK_HZ = 5220;
    localparam int unsigned BEAT   = 64;

    logic        clk;
    logic        rst;
    logic        play;
    logic        loop;
    logic        mute;
    logic [2:0]  volume;
    logic [15:0] left_audio;
    logic [15:0] right_audio;
    logic [3:0]  note_idx;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int cyc    = -1;
    int done_pulses = 0;
    int p0;

    typedef struct {
        int          at;
        logic        play;
        logic        loop;
        logic        mute;
        logic [2:0]  vol;
        logic [3:0]  note;
        logic        busy;
        logic        done;
        logic [15:0] audio;
    } vec_t;

    vec_t tab [$];

    melody_player #(
        .CLK_HZ      (CLK_HZ),
        .BEAT_CYCLES (BEAT),
        .SCORE_DEPTH (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .play        (play),
        .loop        (loop),
        .mute        (mute),
        .volume      (volume),
        .left_audio  (left_audio),
        .right_audio (right_audio),
        .note_idx    (note_idx),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_pulses++;
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] n, input logic b,
                           input logic d, input logic [15:0] a);
        chk({tag, "_note"},  16'(note_idx), 16'(n));
        chk({tag, "_busy"},  16'(busy),     16'(b));
        chk({tag, "_done"},  16'(done),     16'(d));
        chk({tag, "_left"},  left_audio,    a);
        chk({tag, "_right"}, right_audio,   a);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic advance_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        play   = 1'b0;
        loop   = 1'b0;
        mute   = 1'b0;
        volume = 3'd1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic add(input int at, input logic [3:0] n, input logic b,
                       input logic d, input logic [15:0] a);
        vec_t v;
        v.at = at; v.play = 1'b1; v.loop = 1'b0; v.mute = 1'b0; v.vol = 3'd1;
        v.note = n; v.busy = b; v.done = d; v.audio = a;
        tab.push_back(v);
    endtask

    initial begin
        // full score at volume 1, no loop; edge 0 is the first edge with play=1
        add(0,   4'd0, 1, 0, 16'h0000);
        add(1,   4'd1, 1, 0, 16'h0000);
        add(2,   4'd1, 1, 0, 16'h1000);
        add(11,  4'd1, 1, 0, 16'h1000);
        add(12,  4'd1, 1, 0, 16'hF000);
        add(21,  4'd1, 1, 0, 16'hF000);
        add(22,  4'd1, 1, 0, 16'h1000);
        add(64,  4'd1, 1, 0, 16'h1000);
        add(65,  4'd0, 1, 0, 16'h1000);
        add(66,  4'd2, 1, 0, 16'h0000);
        add(67,  4'd2, 1, 0, 16'h1000);
        add(75,  4'd2, 1, 0, 16'h1000);
        add(76,  4'd2, 1, 0, 16'hF000);
        add(131, 4'd3, 1, 0, 16'h0000);
        add(139, 4'd3, 1, 0, 16'h1000);
        add(140, 4'd3, 1, 0, 16'hF000);
        add(196, 4'd4, 1, 0, 16'h0000);
        add(203, 4'd4, 1, 0, 16'h1000);
        add(204, 4'd4, 1, 0, 16'hF000);
        add(261, 4'd5, 1, 0, 16'h0000);
        add(326, 4'd6, 1, 0, 16'h0000);
        add(332, 4'd6, 1, 0, 16'h1000);
        add(333, 4'd6, 1, 0, 16'hF000);
        add(391, 4'd7, 1, 0, 16'h0000);
        add(456, 4'd8, 1, 0, 16'h0000);
        add(461, 4'd8, 1, 0, 16'h1000);
        add(462, 4'd8, 1, 0, 16'hF000);
        add(519, 4'd8, 1, 0, 16'h1000);
        add(520, 4'd0, 1, 0, 16'h1000);
        add(521, 4'd0, 1, 0, 16'h0000);
        add(530, 4'd0, 1, 0, 16'h0000);
        add(584, 4'd0, 1, 0, 16'h0000);
        add(585, 4'd0, 1, 0, 16'h0000);
        add(586, 4'd0, 0, 1, 16'h0000);
        add(587, 4'd0, 0, 0, 16'h0000);
        add(600, 4'd0, 0, 0, 16'h0000);

        do_reset();
        chk_out("reset", 4'd0, 0, 0, 16'h0000);

        // table-driven full score
        p0  = done_pulses;
        cyc = -1;
        for (int i = 0; i < tab.size(); i++) begin
            play   = tab[i].play;
            loop   = tab[i].loop;
            mute   = tab[i].mute;
            volume = tab[i].vol;
            advance_to(tab[i].at);
            chk_out($sformatf("score_v%0d", i), tab[i].note, tab[i].busy,
                    tab[i].done, tab[i].audio);
        end
        chk("score_done_pulses", 16'(done_pulses - p0), 16'd1);
        play = 1'b0;
        tick();
        chk_out("score_stop", 4'd0, 0, 0, 16'h0000);

        // looping: END costs one extra fetch, no done pulse
        do_reset();
        loop = 1'b1;
        p0   = done_pulses;
        play = 1'b1;
        cyc  = -1;
        advance_to(1);
        chk_out("loop_first", 4'd1, 1, 0, 16'h0000);
        advance_to(585);
        chk_out("loop_end", 4'd0, 1, 0, 16'h0000);
        advance_to(586);
        chk_out("loop_refetch", 4'd0, 1, 0, 16'h0000);
        advance_to(587);
        chk_out("loop_again", 4'd1, 1, 0, 16'h0000);
        advance_to(588);
        chk_out("loop_tone", 4'd1, 1, 0, 16'h1000);
        chk("loop_no_done", 16'(done_pulses - p0), 16'd0);

        // stop mid-note 3, then restart from note 1
        do_reset();
        play = 1'b1;
        cyc  = -1;
        advance_to(150);
        chk_out("stop_before", 4'd3, 1, 0, 16'h1000);
        play = 1'b0;
        tick();
        chk_out("stop_idle", 4'd0, 0, 0, 16'h0000);
        repeat (3) tick();
        chk_out("stop_hold", 4'd0, 0, 0, 16'h0000);
        play = 1'b1;
        cyc  = -1;
        advance_to(0);
        chk_out("restart_fetch", 4'd0, 1, 0, 16'h0000);
        advance_to(1);
        chk_out("restart_note1", 4'd1, 1, 0, 16'h0000);
        advance_to(2);
        chk_out("restart_tone", 4'd1, 1, 0, 16'h1000);

        // volume 7, mute across a note boundary, volume 0, volume 3
        do_reset();
        volume = 3'd7;
        play   = 1'b1;
        cyc    = -1;
        advance_to(2);
        chk_out("vol7_pos", 4'd1, 1, 0, 16'h7000);
        advance_to(12);
        chk_out("vol7_neg", 4'd1, 1, 0, 16'h9000);
        advance_to(20);
        mute = 1'b1;
        advance_to(21);
        chk_out("mute_on", 4'd1, 1, 0, 16'h0000);
        advance_to(65);
        chk_out("mute_fetch", 4'd0, 1, 0, 16'h0000);
        advance_to(66);
        chk_out("mute_note2", 4'd2, 1, 0, 16'h0000);
        advance_to(70);
        mute   = 1'b0;
        volume = 3'd0;
        advance_to(80);
        chk_out("vol0", 4'd2, 1, 0, 16'h0000);
        volume = 3'd3;
        advance_to(81);
        chk_out("vol3_neg", 4'd2, 1, 0, 16'hD000);
        advance_to(85);
        chk_out("vol3_pos", 4'd2, 1, 0, 16'h3000);

        // one-cycle reset in the middle of a note
        do_reset();
        play = 1'b1;
        cyc  = -1;
        advance_to(30);
        chk_out("rst_before", 4'd1, 1, 0, 16'h1000);
        rst = 1'b1;
        tick();
        chk_out("rst_applied", 4'd0, 0, 0, 16'h0000);
        rst = 1'b0;
        tick();
        chk_out("rst_fetch", 4'd0, 1, 0, 16'h0000);
        tick();
        chk_out("rst_note1", 4'd1, 1, 0, 16'h0000);
        tick();
        chk_out("rst_tone", 4'd1, 1, 0, 16'h1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
